// File: rtl/lisa_data_mem_hs_pkg.sv
// Shared types for the LISA handshaked data memory: access-size and FSM
// state encodings plus the wait-state counter width.
package lisa_dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Holds 0..15 wait states.
    localparam int WCNT_W = 4;

endpackage

// File: rtl/lisa_data_mem_hs_if.sv
// Request/response bus between the load/store unit (master) and the
// data memory (slave). Carries req_*, rsp_* and the busy status flag.
interface lisa_data_mem_hs_if
    import lisa_dmem_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/lisa_data_mem_hs_byte_array.sv
// Byte storage with four lanes; lane i addresses base+i.
// Ports: clk_i, base_addr_i, we_i[3:0], wdata_i, rdata_o (combinational),
// in_range_o[3:0] (lane address below MEM_BYTES).
module lisa_dmem_byte_array
    import lisa_dmem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic [31:0] base_addr_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  in_range_o
);
    localparam int IDX_W = $clog2(MEM_BYTES);

    // Zero at time zero only; reset never clears storage.
    logic [7:0] mem_q [MEM_BYTES] = '{default: 8'h00};

    logic [32:0]      lane_addr [4];
    logic [IDX_W-1:0] lane_idx  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            // 33-bit sum so addresses never wrap back into range.
            lane_addr[i]  = {1'b0, base_addr_i} + 33'(i);
            lane_idx[i]   = base_addr_i[IDX_W-1:0] + IDX_W'(i);
            in_range_o[i] = lane_addr[i] < 33'(MEM_BYTES);
            rdata_o[8*i +: 8] = in_range_o[i] ? mem_q[lane_idx[i]] : 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i] && in_range_o[i]) begin
                mem_q[lane_idx[i]] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/lisa_data_mem_hs.sv
// LISA data memory with valid/ready request/response handshake,
// byte/half/word little-endian accesses, sign extension, bounds errors and
// WAIT_STATES stall cycles. Ports: clk, rst (async, active-high), bus (slave
// modport: req_*, rsp_*, busy). Optional macro LISA_DMEM_ALIGN_CHECK_EN
// turns misaligned half/word accesses into error responses.
module lisa_data_mem_hs
    import lisa_dmem_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               rst,
    lisa_data_mem_hs_if.slave  bus
);
    state_e            state_q;
    logic [WCNT_W-1:0] cnt_q;
    logic              wr_q;
    logic              sgn_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              busy_q;

    logic [3:0]  lane_mask_d;
    logic [3:0]  we_d;
    logic [3:0]  in_range;
    logic [31:0] arr_rdata;
    logic [31:0] raw_d;
    logic [31:0] ld_d;
    logic [31:0] rdata_d;
    logic        misalign_d;
    logic        err_d;

    lisa_dmem_byte_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clk_i       (clk),
        .base_addr_i (32'(addr_q)),
        .we_i        (we_d),
        .wdata_i     (wdata_q),
        .rdata_o     (arr_rdata),
        .in_range_o  (in_range)
    );

    always_comb begin
        lane_mask_d = 4'b0000;
        unique case (size_q)
            SZ_BYTE: lane_mask_d = 4'b0001;
            SZ_HALF: lane_mask_d = 4'b0011;
            SZ_WORD: lane_mask_d = 4'b1111;
            default: lane_mask_d = 4'b0000;
        endcase
    end

`ifdef LISA_DMEM_ALIGN_CHECK_EN
    assign misalign_d = (size_q == SZ_HALF && addr_q[0]) ||
                        (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
`else
    assign misalign_d = 1'b0;
`endif

    // Stores only commit during the single ACCESS cycle.
    assign we_d = (state_q == ST_ACCESS && wr_q && !misalign_d)
                ? lane_mask_d : 4'b0000;

    assign err_d = (size_q == SZ_RSVD) || misalign_d ||
                   (|(lane_mask_d & ~in_range));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            raw_d[8*i +: 8] = lane_mask_d[i] ? arr_rdata[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        ld_d = 32'h0;
        unique case (size_q)
            SZ_BYTE: ld_d = {{24{sgn_q & raw_d[7]}}, raw_d[7:0]};
            SZ_HALF: ld_d = {{16{sgn_q & raw_d[15]}}, raw_d[15:0]};
            SZ_WORD: ld_d = raw_d;
            default: ld_d = 32'h0;
        endcase
    end

    assign rdata_d = (wr_q || misalign_d) ? 32'h0 : ld_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q        <= bus.req_write;
                        size_q      <= size_e'(bus.req_size);
                        sgn_q       <= bus.req_signed;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (WAIT_STATES > 0) ? ST_WAIT
                                                         : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == WCNT_W'(WAIT_STATES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    rsp_rdata_q <= rdata_d;
                    rsp_err_q   <= err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lisa_data_mem_hs.sv
// Bench for lisa_data_mem_hs: one instance with no wait states and one
// with three, checked against a byte-array model and literal values.
module tb_lisa_data_mem_hs;
    import lisa_dmem_pkg::*;

    localparam int MB = 1024;
`ifdef LISA_DMEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lisa_data_mem_hs_if #(.ADDR_W(16)) b0 ();
    lisa_data_mem_hs_if #(.ADDR_W(16)) b1 ();

    lisa_data_mem_hs #(
        .MEM_BYTES(MB), .ADDR_W(16), .WAIT_STATES(0)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    lisa_data_mem_hs #(
        .MEM_BYTES(MB), .ADDR_W(16), .WAIT_STATES(3)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    logic [1:0]  o_rv, o_rr, o_er, o_bz;
    logic [31:0] o_rd [2];
    assign o_rv = {b1.rsp_valid, b0.rsp_valid};
    assign o_rr = {b1.req_ready, b0.req_ready};
    assign o_er = {b1.rsp_err, b0.rsp_err};
    assign o_bz = {b1.busy, b0.busy};
    assign o_rd[0] = b0.rsp_rdata;
    assign o_rd[1] = b1.rsp_rdata;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", nm, act, exp);
    endfunction

    function automatic void chkb(string nm, logic act, logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", nm, act, exp);
    endfunction

    // Model: per-instance byte image plus the current request.
    logic [7:0]  mdl  [2][MB];
    bit          pend [2];
    logic [31:0] e_rd [2];
    bit          e_er [2];
    bit          q_wr [2];
    logic [1:0]  q_sz [2];
    bit          q_sg [2];
    int unsigned q_a  [2];
    logic [31:0] q_wd [2];

    function automatic void model(input int d, input bit commit,
                                  output logic [31:0] rd, output bit er);
        int n;
        int ad;
        rd = 32'h0;
        er = 1'b0;
        if (q_sz[d] == 2'd3) begin
            er = 1'b1;
            return;
        end
        n = 1 << q_sz[d];
        if (ALN && (q_a[d] % n) != 0) begin
            er = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            ad = int'(q_a[d]) + i;
            if (ad >= MB) er = 1'b1;
            else if (q_wr[d]) begin
                if (commit) mdl[d][ad] = q_wd[d][8*i +: 8];
            end else rd[8*i +: 8] = mdl[d][ad];
        end
        if (!q_wr[d] && q_sg[d] && n < 4 && rd[8*n-1])
            rd = rd | (32'hFFFF_FFFF << (8*n));
    endfunction

    task automatic drive(input int d, input bit v, input bit wr,
                         input logic [1:0] sz, input bit sg,
                         input int unsigned a, input logic [31:0] wd);
        if (d == 0) begin
            b0.req_valid = v; b0.req_write = wr; b0.req_size = sz;
            b0.req_signed = sg; b0.req_addr = a[15:0]; b0.req_wdata = wd;
        end else begin
            b1.req_valid = v; b1.req_write = wr; b1.req_size = sz;
            b1.req_signed = sg; b1.req_addr = a[15:0]; b1.req_wdata = wd;
        end
    endtask

    task automatic set_rr(input int d, input bit r);
        if (d == 0) b0.rsp_ready = r;
        else b1.rsp_ready = r;
    endtask

    // One transaction; returns the first observed response and latency.
    task automatic issue(input int d, input bit wr, input logic [1:0] sz,
                         input bit sg, input int unsigned a,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output bit er);
        int lat;
        bit got;
        logic [31:0] tr;
        bit te;
        q_wr[d] = wr; q_sz[d] = sz; q_sg[d] = sg; q_a[d] = a; q_wd[d] = wd;
        model(d, 1'b0, tr, te);
        e_rd[d] = tr;
        e_er[d] = te;
        @(posedge clk); #1;
        drive(d, 1'b1, wr, sz, sg, a, wd);
        set_rr(d, hold == 0);
        pend[d] = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 drive(d, 1'b0, ~wr, 2'd2, ~sg, a ^ 32'h5555, ~wd);
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (o_rv[d]) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chkb($sformatf("rsp_seen%0d", d), got, 1'b1);
        chk($sformatf("latency%0d", d), 32'(lat), 32'(d == 0 ? 2 : 5));
        rd = o_rd[d];
        er = o_er[d];
        if (hold > 0) begin
            // A second request offered during RESP must be ignored.
            drive(d, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0100, 32'hFFFF_FFFF);
            repeat (hold) @(negedge clk);
            drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
            set_rr(d, 1'b1);
        end
        @(posedge clk); #1;
        chkb($sformatf("rsp_drop%0d", d), o_rv[d], 1'b0);
        chkb($sformatf("ready_back%0d", d), o_rr[d], 1'b1);
        chkb($sformatf("idle%0d", d), o_bz[d], 1'b0);
        model(d, 1'b1, tr, te);
        pend[d] = 1'b0;
    endtask

    // Every cycle a response is up, it must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (o_rv[d]) begin
                    chkb($sformatf("pending%0d", d), pend[d], 1'b1);
                    chk($sformatf("rdata%0d", d), o_rd[d], e_rd[d]);
                    chkb($sformatf("err%0d", d), o_er[d], e_er[d]);
                    chkb($sformatf("rdy_low%0d", d), o_rr[d], 1'b0);
                    chkb($sformatf("busy%0d", d), o_bz[d], 1'b1);
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chkb($sformatf("%s_rdy%0d", tag, d), o_rr[d], 1'b1);
            chkb($sformatf("%s_vld%0d", tag, d), o_rv[d], 1'b0);
            chk($sformatf("%s_rd%0d", tag, d), o_rd[d], 32'h0);
            chkb($sformatf("%s_err%0d", tag, d), o_er[d], 1'b0);
            chkb($sformatf("%s_busy%0d", tag, d), o_bz[d], 1'b0);
        end
    endtask

    logic [31:0] rd;
    bit          er;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < MB; i++) mdl[d][i] = 8'h00;
            pend[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
            set_rr(d, 1'b1);
        end
        #1 rst = 1'b1;
        #2 chk_reset_vals("reset");
        @(negedge clk); #1 rst = 1'b0;

        issue(0, 1, 2'd2, 0, 32'h0010, 32'hDEAD_BEEF, 0, rd, er);
        chk("st_word_rd", rd, 32'h0);
        chkb("st_word_err", er, 1'b0);
        issue(0, 0, 2'd0, 1, 32'h0013, 32'h0, 0, rd, er);
        chk("ld_sbyte", rd, 32'hFFFF_FFDE);
        chkb("ld_sbyte_err", er, 1'b0);

        issue(0, 1, 2'd1, 0, 32'h0021, 32'hABCD_8001, 0, rd, er);
        chkb("st_half_err", er, ALN);
        issue(0, 0, 2'd1, 0, 32'h0021, 32'h0, 0, rd, er);
        chk("ld_uhalf", rd, ALN ? 32'h0 : 32'h0000_8001);
        issue(0, 0, 2'd1, 1, 32'h0021, 32'h0, 0, rd, er);
        chk("ld_shalf", rd, ALN ? 32'h0 : 32'hFFFF_8001);
        issue(0, 0, 2'd2, 0, 32'h0020, 32'h0, 0, rd, er);
        chk("ld_word20", rd, ALN ? 32'h0 : 32'h0080_0100);

        issue(0, 1, 2'd2, 0, 32'h03FE, 32'h1122_3344, 0, rd, er);
        chkb("st_oob_err", er, 1'b1);
        issue(0, 0, 2'd2, 0, 32'h03FC, 32'h0, 0, rd, er);
        chk("ld_edge", rd, ALN ? 32'h0 : 32'h3344_0000);
        chkb("ld_edge_err", er, 1'b0);
        issue(0, 0, 2'd2, 0, 32'h0400, 32'h0, 0, rd, er);
        chk("ld_oob", rd, 32'h0);
        chkb("ld_oob_err", er, 1'b1);

        issue(0, 0, 2'd3, 1, 32'h0010, 32'h0, 0, rd, er);
        chk("ld_rsvd", rd, 32'h0);
        chkb("ld_rsvd_err", er, 1'b1);

        issue(0, 1, 2'd2, 0, 32'h0042, 32'h55AA_55AA, 0, rd, er);
        chkb("st_mis_err", er, ALN);
        issue(0, 0, 2'd2, 0, 32'h0040, 32'h0, 0, rd, er);
        chk("ld_mis40", rd, ALN ? 32'h0 : 32'h55AA_0000);

        issue(1, 1, 2'd2, 0, 32'h0080, 32'h1234_5678, 5, rd, er);
        chkb("ws_st_err", er, 1'b0);
        issue(1, 0, 2'd2, 0, 32'h0080, 32'h0, 5, rd, er);
        chk("ws_ld", rd, 32'h1234_5678);
        issue(1, 0, 2'd2, 0, 32'h0100, 32'h0, 0, rd, er);
        chk("ws_ignored_req", rd, 32'h0);

        // Reset while a store sits in WAIT: it must be abandoned.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0040, 32'hCAFE_F00D);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
        @(posedge clk); #2;
        chkb("busy_before_rst", o_bz[1], 1'b1);
        rst = 1'b1;
        #1 chk_reset_vals("midrst");
        @(negedge clk); #1 rst = 1'b0;
        issue(1, 0, 2'd2, 0, 32'h0040, 32'h0, 0, rd, er);
        chk("rst_ld40", rd, 32'h0);
        chkb("rst_ld40_err", er, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
